seq_multiplier: RTL and testbench

- Multi-cycle shift-add multiply unit; owns the architectural HI/LO registers.
- Sits directly downstream of the datapath's operand selection: receives rs/rt values (srca/srcb) plus a start pulse from the decoder on MULT/MULTU.
- Drives hi/lo back to the result mux for MFHI/MFLO.
- Raises busy so the controller stalls the PC while a product is in flight.

---
 rtl/mul_pkg.sv | 13 +
 rtl/mag_sign.sv | 16 +
 rtl/seq_multiplier.sv | 116 +++++++++++
 tb/tb_seq_multiplier.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and sizing for the shift-add multiply unit.
package mul_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_CNT_W = $clog2(MUL_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mag_sign.sv
// Two's-complement conditional negate: y = neg ? -x : x.
// Used both to take operand magnitudes and to restore the product sign.
module mag_sign #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);

  logic [W-1:0] one;

  assign one = {{(W-1){1'b0}}, 1'b1};
  assign y   = neg ? (~x + one) : x;

endmodule

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier owning the HI/LO registers (MULT/MULTU, MTHI/MTLO).
//
// state | meaning
// IDLE  | waiting; accepts start and MTHI/MTLO writes
// BUSY  | one shift-add iteration per cycle, hi/lo frozen
// DONE  | product just stored in hi/lo; done=1, accepts start/MTHI/MTLO
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH == MUL_WIDTH) ? MUL_CNT_W : $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mul_state_t         state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplr;
  logic [WIDTH-1:0]   acc;
  logic               sign_q;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod_u;
  logic [2*WIDTH-1:0] prod;

  mag_sign #(.W(WIDTH)) u_mag_a (
    .x   (a),
    .neg (is_signed & a[WIDTH-1]),
    .y   (mag_a)
  );

  mag_sign #(.W(WIDTH)) u_mag_b (
    .x   (b),
    .neg (is_signed & b[WIDTH-1]),
    .y   (mag_b)
  );

  // Carry out of the add lands in sum[WIDTH] and shifts down into the accumulator.
  assign sum    = {1'b0, acc} + (mplr[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
  assign prod_u = {sum, mplr[WIDTH-1:1]};

  mag_sign #(.W(2*WIDTH)) u_neg (
    .x   (prod_u),
    .neg (sign_q),
    .y   (prod)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplr   <= '0;
      acc    <= '0;
      sign_q <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          // In DONE the product was stored last edge, so a write here wins.
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            mcand  <= mag_a;
            mplr   <= mag_b;
            acc    <= '0;
            sign_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= BUSY;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          acc  <= sum[WIDTH:1];
          mplr <= {sum[0], mplr[WIDTH-1:1]};
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            hi    <= prod[2*WIDTH-1:WIDTH];
            lo    <= prod[WIDTH-1:0];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed cases plus random operands
// against a 64-bit arithmetic reference for the product and HI/LO contents.
module tb_seq_multiplier;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          is_signed;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          hi_we;
  logic          lo_we;
  logic [W-1:0]  wdata;
  logic          busy;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_hi;
  logic [W-1:0] exp_lo;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: full-width product of the (sign- or zero-) extended operands, mod 2^64.
  function automatic logic [63:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic s);
    logic [63:0] xe, ye;
    xe = s ? {{32{x[W-1]}}, x} : {32'b0, x};
    ye = s ? {{32{y[W-1]}}, y} : {32'b0, y};
    return xe * ye;
  endfunction

  // Starts a multiply in the current cycle and returns in its done cycle.
  // inj=1: spurious start mid-flight; inj=2: MTLO attempt mid-flight.
  task automatic run_mul(input logic [W-1:0] ma, input logic [W-1:0] mb,
                         input logic ms, input int inj);
    logic [63:0] p;
    logic [W-1:0] old_hi, old_lo;
    int nb;
    logic hold_ok;
    p = model(ma, mb, ms);
    old_hi = exp_hi;
    old_lo = exp_lo;
    a = ma; b = mb; is_signed = ms; start = 1'b1;
    tick();
    start = 1'b0; a = $urandom; b = $urandom; is_signed = $urandom_range(0, 1);
    nb = 0;
    hold_ok = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (busy && !done) nb++;
      if (hi !== old_hi || lo !== old_lo) hold_ok = 1'b0;
      if (i == 5 && inj == 1) begin start = 1'b1; a = 32'h1; b = 32'h1; is_signed = 1'b0; end
      if (i == 5 && inj == 2) begin lo_we = 1'b1; wdata = 32'hdeadbeef; end
      tick();
      start = 1'b0;
      lo_we = 1'b0;
    end
    check("busy_cycles", nb, W);
    check("hold_during_busy", hold_ok, 1);
    check("done_pulse", done, 1);
    check("busy_at_done", busy, 0);
    check("hi", hi, p[63:32]);
    check("lo", lo, p[31:0]);
    exp_hi = p[63:32];
    exp_lo = p[31:0];
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      if (done) n++;
      tick();
    end
  endtask

  initial begin
    int nd;
    logic [W-1:0] ra, rb;
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    exp_hi = '0; exp_lo = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    tick();

    run_mul(32'd7, 32'd6, 1'b0, 0);
    // back-to-back: start in the DONE cycle
    run_mul(32'd3, 32'd5, 1'b0, 0);
    tick();
    check("idle_after_done", done, 0);

    run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0); tick();
    run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 0); tick();
    run_mul(32'hFFFFFFFE, 32'd3, 1'b1, 0); tick();
    run_mul(32'h80000000, 32'h80000000, 1'b1, 0); tick();
    run_mul(32'h80000000, 32'h80000000, 1'b0, 0); tick();

    // spurious start during BUSY
    run_mul(32'd1234, 32'd5678, 1'b0, 1);
    tick();
    check("no_restart_busy", busy, 0);
    count_done(40, nd);
    check("no_extra_done", nd, 0);
    check("hi_after_ignored", hi, exp_hi);
    check("lo_after_ignored", lo, exp_lo);

    // MTLO while BUSY is ignored (hold check inside run_mul)
    run_mul(32'h00010001, 32'hFFFF0000, 1'b1, 2);
    // MTLO in DONE wins over the stored product
    lo_we = 1'b1; wdata = 32'hCAFEF00D;
    tick();
    lo_we = 1'b0;
    exp_lo = 32'hCAFEF00D;
    check("mtlo_done_lo", lo, exp_lo);
    check("mtlo_done_hi", hi, exp_hi);

    // MTHI in IDLE, then both halves together
    hi_we = 1'b1; wdata = 32'h12345678;
    tick();
    hi_we = 1'b0;
    exp_hi = 32'h12345678;
    check("mthi_idle", hi, exp_hi);
    check("mthi_lo_kept", lo, exp_lo);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_5A5A;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    exp_hi = 32'hA5A5_5A5A; exp_lo = 32'hA5A5_5A5A;
    check("mthilo_hi", hi, exp_hi);
    check("mthilo_lo", lo, exp_lo);

    // random operands, sometimes back-to-back
    for (int k = 0; k < 24; k++) begin
      ra = $urandom;
      rb = $urandom;
      if (k % 4 == 1) rb = 32'h80000000;
      if (k % 4 == 2) ra = '0;
      run_mul(ra, rb, 1'($urandom_range(0, 1)), 0);
      if ($urandom_range(0, 1) == 1) tick();
    end
    tick();

    // reset mid-operation
    a = 32'h10; b = 32'h10; is_signed = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    check("busy_before_rst", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    count_done(40, nd);
    check("midrst_no_done", nd, 0);
    check("midrst_lo_after", lo, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
